alu_sequencer: RTL

- Multi-cycle control FSM for the LITE-16 core.
- Fetches 16-bit instructions over a req/ack instruction-memory handshake, decodes them and drives register-file addresses and the ALU controls (codeop, ri, immediate).
- Sequences writeback, and takes compare-branches from the ALU cmp flag.
- Sits between the instruction memory and the register-file/ALU datapath.

---
 rtl/lite16_pkg.sv | 55 +++++
 rtl/lite16_instr_decode.sv | 34 +++
 rtl/alu_sequencer.sv | 129 ++++++++++++
 3 files changed

// File: rtl/lite16_pkg.sv
// lite16_pkg: shared definitions for the LITE-16 control path.
//   - instruction field bit positions and widths
//   - codeop constants (3'b111 is the compare-branch / halt escape)
//   - sequencer state encoding
//   - decoded-instruction record and sign-extension helpers
package lite16_pkg;

  localparam int INSTR_W = 16;
  localparam int IMM_W   = 8;
  localparam int OFF_W   = 4;

  // Instruction field bit positions
  localparam int CODEOP_HI = 15;
  localparam int CODEOP_LO = 13;
  localparam int RI_BIT    = 12;
  localparam int RD_HI     = 11;
  localparam int RD_LO     = 8;
  localparam int RA_HI     = 7;
  localparam int RA_LO     = 4;
  localparam int RB_HI     = 3;
  localparam int RB_LO     = 0;

  // Codeops other than CMP_BR_HALT are passed straight to the ALU.
  localparam logic [2:0] CMP_BR_HALT = 3'b111;

  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXECUTE   = 3'd2,
    S_WRITEBACK = 3'd3,
    S_HALT      = 3'd4
  } state_e;

  typedef struct packed {
    logic [2:0]         codeop;
    logic               ri;
    logic [3:0]         rd;
    logic [3:0]         ra;
    logic [3:0]         rb;
    logic [INSTR_W-1:0] imm;     // sign-extended imm8
    logic [INSTR_W-1:0] offset;  // sign-extended branch offset (rd field)
    logic               is_branch;
    logic               is_halt;
    logic               is_wb;
  } decoded_t;

  function automatic logic [INSTR_W-1:0] sext_imm(input logic [IMM_W-1:0] v);
    return {{(INSTR_W-IMM_W){v[IMM_W-1]}}, v};
  endfunction

  function automatic logic [INSTR_W-1:0] sext_off(input logic [OFF_W-1:0] v);
    return {{(INSTR_W-OFF_W){v[OFF_W-1]}}, v};
  endfunction

endpackage

// File: rtl/lite16_instr_decode.sv
// lite16_instr_decode: purely combinational instruction decoder.
//   ir  in  16  instruction register
//   dec out     decoded fields, sign-extended immediate and branch offset,
//               and is_branch / is_halt / is_wb classification
module lite16_instr_decode
  import lite16_pkg::*;
(
  input  logic [INSTR_W-1:0] ir,
  output decoded_t           dec
);

  logic special;

  assign special = (ir[CODEOP_HI:CODEOP_LO] == CMP_BR_HALT);

  always_comb begin
    // NOTE: every field gets a default first so no path leaves dec
    // unassigned, which would otherwise infer a latch.
    dec           = '0;
    dec.codeop    = ir[CODEOP_HI:CODEOP_LO];
    dec.ri        = ir[RI_BIT];
    dec.rd        = ir[RD_HI:RD_LO];
    dec.ra        = ir[RA_HI:RA_LO];
    dec.rb        = ir[RB_HI:RB_LO];
    dec.imm       = sext_imm(ir[IMM_W-1:0]);
    dec.offset    = sext_off(ir[RD_HI:RD_LO]);
    dec.is_branch = special && !ir[RI_BIT];
    dec.is_halt   = special &&  ir[RI_BIT];
    dec.is_wb     = !special;
    // Immediate forms use rd as the a-operand (rd <= rd op imm).
    if (ir[RI_BIT]) dec.ra = ir[RD_HI:RD_LO];
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle control FSM for the LITE-16 core.
// Fetches over a req/ack instruction-memory handshake, decodes, drives the
// register-file addresses and ALU controls, sequences writeback and takes
// compare-branches from alu_cmp.
//   clk, rst           clock, synchronous active-high reset
//   run                permits a new fetch (looked at only in FETCH)
//   imem_req/addr/ack/data  instruction-memory handshake; addr == pc
//   rf_ra/rb/rd_addr   register-file addresses (rd is also the write address)
//   rf_we              one-cycle write strobe in WRITEBACK
//   alu_codeop/ri/imm  ALU controls, updated on entry to EXECUTE
//   alu_cmp            ALU compare flag, sampled for branches
//   pc, halted, fault  program counter and stop status
module alu_sequencer
  import lite16_pkg::*;
#(
  parameter logic [15:0] RESET_PC      = 16'h0000,
  parameter int          FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  output logic [3:0]  rf_rd_addr,
  output logic        rf_we,
  output logic [2:0]  alu_codeop,
  output logic        alu_ri,
  output logic [15:0] alu_imm,
  input  logic        alu_cmp,
  output logic [15:0] pc,
  output logic        halted,
  output logic        fault
);

  localparam logic [15:0] TIMEOUT_LAST = 16'(FETCH_TIMEOUT - 1);

  state_e      state;
  logic [15:0] ir;
  logic [15:0] instr_addr;
  logic [15:0] wait_cnt;
  decoded_t    dec;

  lite16_instr_decode u_decode (
    .ir  (ir),
    .dec (dec)
  );

  // Register-file addresses follow IR, so they are valid from DECODE
  // through WRITEBACK and read as zero after reset (IR = 0).
  assign imem_addr  = pc;
  assign rf_ra_addr = dec.ra;
  assign rf_rb_addr = dec.rb;
  assign rf_rd_addr = dec.rd;

  // NOTE: all state here is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_FETCH;
      pc         <= RESET_PC;
      ir         <= '0;
      instr_addr <= '0;
      wait_cnt   <= '0;
      imem_req   <= 1'b0;
      rf_we      <= 1'b0;
      alu_codeop <= '0;
      alu_ri     <= 1'b0;
      alu_imm    <= '0;
      halted     <= 1'b0;
      fault      <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (imem_req && imem_ack) begin
            ir         <= imem_data;
            instr_addr <= pc;
            pc         <= pc + 16'd1;
            imem_req   <= 1'b0;
            wait_cnt   <= '0;
            state      <= S_DECODE;
          end else if (!run) begin
            // Dropping run also abandons a request that has not been acked.
            imem_req <= 1'b0;
            wait_cnt <= '0;
          end else if (imem_req) begin
            if (wait_cnt == TIMEOUT_LAST) begin
              fault    <= 1'b1;
              halted   <= 1'b1;
              imem_req <= 1'b0;
              state    <= S_HALT;
            end else begin
              wait_cnt <= wait_cnt + 16'd1;
            end
          end else begin
            imem_req <= 1'b1;
          end
        end
        S_DECODE: begin
          alu_codeop <= dec.codeop;
          alu_ri     <= dec.ri;
          alu_imm    <= dec.imm;
          state      <= S_EXECUTE;
        end
        S_EXECUTE: begin
          if (dec.is_wb) begin
            rf_we <= 1'b1;
            state <= S_WRITEBACK;
          end else if (dec.is_branch) begin
            // Target is relative to the branch itself, not to pc+1.
            if (alu_cmp) pc <= instr_addr + dec.offset;
            state <= S_FETCH;
          end else begin
            halted <= 1'b1;
            state  <= S_HALT;
          end
        end
        S_WRITEBACK: state <= S_FETCH;
        S_HALT:      state <= S_HALT;
        default:     state <= S_FETCH;
      endcase
    end
  end

endmodule
